// File: rtl/pipeline_sink_fifo.sv
// rtl/pipeline_sink_fifo.sv - show-ahead circular FIFO turning a free-running word stream into valid/ready
// Optional drop accounting (overflow, drop_cnt) enabled by PIPELINE_SINK_FIFO_OVF_EN.
module pipeline_sink_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             is_full;
  logic             pop;
  logic             push;

  assign is_full   = (cnt_q == FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign in_ready  = !is_full;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a word when the head is leaving on the same edge.
  assign push      = in_valid && (!is_full || pop);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef PIPELINE_SINK_FIFO_OVF_EN
  logic       drop;
  logic       ovf_q;
  logic [7:0] drop_q;

  assign drop = in_valid && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
`else
  assign overflow = 1'b0;
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pipeline_sink_fifo.sv
// tb/tb_pipeline_sink_fifo.sv - queue-model and directed-vector bench for pipeline_sink_fifo
module tb_pipeline_sink_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef PIPELINE_SINK_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int total = 0;
  int bad = 0;

  pipeline_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of words plus drop bookkeeping.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  int               m_drops;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = out_ready && (mq.size() != 0);
      do_push = in_valid && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(in_data);
      else if (in_valid) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
    chk("m_overflow", 32'(overflow), OVF_EN ? 32'(m_ovf) : 32'd0);
    chk("m_drop_cnt", 32'(drop_cnt), OVF_EN ? 32'(m_drops) : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_words[4];
  logic [WIDTH-1:0] prev;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    chk("idle_count", 32'(count), 32'd0);

    // single word in and out
    push_word(16'h1234);
    chk("one_out_valid", 32'(out_valid), 32'd1);
    chk("one_out_data", 32'(out_data), 32'h1234);
    chk("one_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_pop_valid", 32'(out_valid), 32'd0);
    chk("one_pop_count", 32'(count), 32'd0);

    // fill, overflow, drain
    for (int i = 0; i < 4; i++) push_word(16'hA001 + 16'(i));
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push_word(16'hA005);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), OVF_EN ? 32'd1 : 32'd0);
    chk("ovf_drop_cnt", 32'(drop_cnt), OVF_EN ? 32'd1 : 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_a", 32'(out_data), 32'hA001 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_a_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), OVF_EN ? 32'd1 : 32'd0);

    // full with simultaneous push and pop
    reset_pulse();
    for (int i = 0; i < 4; i++) push_word(16'hB001 + 16'(i));
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk("pp_count", 32'(count), 32'd4);
    exp_words[0] = 16'hB002;
    exp_words[1] = 16'hB003;
    exp_words[2] = 16'hB004;
    exp_words[3] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      chk("drain_b", 32'(out_data), 32'(exp_words[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_b_empty", 32'(out_valid), 32'd0);
    chk("pp_overflow", 32'(overflow), 32'd0);

    // streaming across pointer wrap
    reset_pulse();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_data = 16'($urandom);
      prev = in_data;
      tick();
      chk("stream_data", 32'(out_data), 32'(prev));
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);
    chk("stream_no_drop", 32'(drop_cnt), 32'd0);

    // asynchronous reset with three words held
    for (int i = 0; i < 3; i++) push_word(16'hC001 + 16'(i));
    chk("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    push_word(16'h0042);
    chk("post_rst_data", 32'(out_data), 32'h0042);
    chk("post_rst_count", 32'(count), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
